// File: rtl/tlb_arb_pkg.sv
// Shared types and widths for the sv32 TLB arbiter.
package tlb_arb_pkg;

  localparam int unsigned VPN_W      = 20;
  localparam int unsigned UPD_ASID_W = 9;
  localparam int unsigned PTE_W      = 32;
  localparam int unsigned VADDR_W    = 32;
  localparam int unsigned UPD_DATA_W = 62;
  localparam int unsigned UPD_W      = 63;
  localparam int unsigned BURST_W    = 4;

  // TLB update word: {valid, is_4M, vpn, asid, pte}
  typedef struct packed {
    logic                  valid;
    logic                  is_4M;
    logic [VPN_W-1:0]      vpn;
    logic [UPD_ASID_W-1:0] asid;
    logic [PTE_W-1:0]      pte;
  } tlb_update_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the I side, bit 1 the D side.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt_c
);

  // ptr == 0 favours I, ptr == 1 favours D
  logic ptr;

  // Grant decode: a lone requester wins, a contest goes to the pointer
  always_comb begin
    gnt_c = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt_c = ptr ? 2'b10 : 2'b01;
      end else begin
        gnt_c = req;
      end
    end
  end

  // Pointer only moves after a contested grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (en && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/cva6_tlb_sv32_arbiter.sv
// Shares one sv32 TLB between I/D lookups, PTW refills and sfence.vma flushes.
module cva6_tlb_sv32_arbiter
  import tlb_arb_pkg::*;
#(
  parameter int unsigned ASID_WIDTH    = 1,
  parameter int unsigned MAX_UPD_BURST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  i_req_i,
  input  logic                  d_req_i,
  output logic                  i_gnt_o,
  output logic                  d_gnt_o,
  input  logic [31:0]           i_vaddr_i,
  input  logic [31:0]           d_vaddr_i,
  input  logic [ASID_WIDTH-1:0] i_asid_i,
  input  logic [ASID_WIDTH-1:0] d_asid_i,
  output logic                  i_rvalid_o,
  output logic                  d_rvalid_o,
  output logic                  rhit_o,
  output logic [31:0]           rcontent_o,
  output logic                  ris_4M_o,
  input  logic                  upd_req_i,
  output logic                  upd_gnt_o,
  input  logic [61:0]           upd_data_i,
  input  logic                  flush_req_i,
  output logic                  flush_gnt_o,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic [31:0]           flush_vaddr_i,
  output logic                  busy_o,
  output logic                  tlb_flush_o,
  output logic [62:0]           tlb_update_o,
  output logic                  tlb_lu_access_o,
  output logic [ASID_WIDTH-1:0] tlb_lu_asid_o,
  output logic [31:0]           tlb_lu_vaddr_o,
  output logic [ASID_WIDTH-1:0] tlb_asid_flush_o,
  output logic [31:0]           tlb_vaddr_flush_o,
  input  logic [31:0]           tlb_lu_content_i,
  input  logic                  tlb_lu_hit_i,
  input  logic                  tlb_lu_is_4M_i
);

  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_UPD_BURST);

  arb_state_e         state;
  logic [BURST_W-1:0] burst_cnt;
  logic               lookup_pending;
  logic               upd_blocked;
  logic               lu_en;
  logic [1:0]         lu_gnt;
  tlb_update_t        upd_word;

  assign lookup_pending = i_req_i | d_req_i;
  assign upd_blocked    = (burst_cnt == BURST_MAX) && lookup_pending;

  // Priority decode: flush, then update (burst-limited), then lookup; nothing in HOLD or reset
  always_comb begin
    flush_gnt_o       = 1'b0;
    upd_gnt_o         = 1'b0;
    lu_en             = 1'b0;
    tlb_flush_o       = 1'b0;
    tlb_asid_flush_o  = '0;
    tlb_vaddr_flush_o = '0;
    upd_word          = '0;
    if (rst_ni && (state == IDLE)) begin
      if (flush_req_i) begin
        flush_gnt_o       = 1'b1;
        tlb_flush_o       = 1'b1;
        tlb_asid_flush_o  = flush_asid_i;
        tlb_vaddr_flush_o = flush_vaddr_i;
      end else if (upd_req_i && !upd_blocked) begin
        upd_gnt_o = 1'b1;
        upd_word  = tlb_update_t'({1'b1, upd_data_i});
      end else begin
        lu_en = 1'b1;
      end
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (lu_en),
    .req   ({d_req_i, i_req_i}),
    .gnt_c (lu_gnt)
  );

  assign i_gnt_o         = lu_gnt[0];
  assign d_gnt_o         = lu_gnt[1];
  assign tlb_update_o    = upd_word;
  assign tlb_lu_access_o = lu_gnt[0] | lu_gnt[1];
  assign tlb_lu_asid_o   = lu_gnt[1] ? d_asid_i  : (lu_gnt[0] ? i_asid_i  : '0);
  assign tlb_lu_vaddr_o  = lu_gnt[1] ? d_vaddr_i : (lu_gnt[0] ? i_vaddr_i : '0);
  assign busy_o          = (state == HOLD);

  // FSM, update-burst counter and registered lookup response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      i_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      rhit_o     <= 1'b0;
      rcontent_o <= '0;
      ris_4M_o   <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (flush_gnt_o) state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!lookup_pending || tlb_lu_access_o || flush_gnt_o) begin
        burst_cnt <= '0;
      end else if (upd_gnt_o && (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + BURST_W'(1);
      end

      i_rvalid_o <= lu_gnt[0];
      d_rvalid_o <= lu_gnt[1];
      if (tlb_lu_access_o) begin
        rhit_o     <= tlb_lu_hit_i;
        rcontent_o <= tlb_lu_content_i;
        ris_4M_o   <= tlb_lu_is_4M_i;
      end
    end
  end

endmodule

// File: tb/tb_cva6_tlb_sv32_arbiter.sv
// Directed bench for cva6_tlb_sv32_arbiter with a small direct-mapped TLB model.
module tb_cva6_tlb_sv32_arbiter;
  import tlb_arb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        i_req_i, d_req_i, i_gnt_o, d_gnt_o;
  logic [31:0] i_vaddr_i, d_vaddr_i;
  logic [0:0]  i_asid_i, d_asid_i;
  logic        i_rvalid_o, d_rvalid_o, rhit_o, ris_4M_o;
  logic [31:0] rcontent_o;
  logic        upd_req_i, upd_gnt_o;
  logic [61:0] upd_data_i;
  logic        flush_req_i, flush_gnt_o;
  logic [0:0]  flush_asid_i;
  logic [31:0] flush_vaddr_i;
  logic        busy_o, tlb_flush_o, tlb_lu_access_o;
  logic [62:0] tlb_update_o;
  logic [0:0]  tlb_lu_asid_o, tlb_asid_flush_o;
  logic [31:0] tlb_lu_vaddr_o, tlb_vaddr_flush_o;
  logic [31:0] tlb_lu_content_i;
  logic        tlb_lu_hit_i, tlb_lu_is_4M_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  cva6_tlb_sv32_arbiter #(.ASID_WIDTH(1), .MAX_UPD_BURST(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_req_i(i_req_i), .d_req_i(d_req_i), .i_gnt_o(i_gnt_o), .d_gnt_o(d_gnt_o),
    .i_vaddr_i(i_vaddr_i), .d_vaddr_i(d_vaddr_i), .i_asid_i(i_asid_i), .d_asid_i(d_asid_i),
    .i_rvalid_o(i_rvalid_o), .d_rvalid_o(d_rvalid_o), .rhit_o(rhit_o),
    .rcontent_o(rcontent_o), .ris_4M_o(ris_4M_o),
    .upd_req_i(upd_req_i), .upd_gnt_o(upd_gnt_o), .upd_data_i(upd_data_i),
    .flush_req_i(flush_req_i), .flush_gnt_o(flush_gnt_o),
    .flush_asid_i(flush_asid_i), .flush_vaddr_i(flush_vaddr_i), .busy_o(busy_o),
    .tlb_flush_o(tlb_flush_o), .tlb_update_o(tlb_update_o),
    .tlb_lu_access_o(tlb_lu_access_o), .tlb_lu_asid_o(tlb_lu_asid_o),
    .tlb_lu_vaddr_o(tlb_lu_vaddr_o), .tlb_asid_flush_o(tlb_asid_flush_o),
    .tlb_vaddr_flush_o(tlb_vaddr_flush_o), .tlb_lu_content_i(tlb_lu_content_i),
    .tlb_lu_hit_i(tlb_lu_hit_i), .tlb_lu_is_4M_i(tlb_lu_is_4M_i)
  );

  // TLB model: 4 entries indexed by vpn[1:0], flush clears everything
  logic [3:0]  m_v;
  logic [19:0] m_vpn [4];
  logic [8:0]  m_asid[4];
  logic [31:0] m_pte [4];
  logic        m_4m  [4];
  tlb_update_t upd_w;
  assign upd_w = tlb_update_t'(tlb_update_o);

  initial m_v = '0;

  always @(posedge clk_i) begin
    if (tlb_flush_o) begin
      m_v <= '0;
    end else if (upd_w.valid) begin
      m_v[upd_w.vpn[1:0]]    <= 1'b1;
      m_vpn[upd_w.vpn[1:0]]  <= upd_w.vpn;
      m_asid[upd_w.vpn[1:0]] <= upd_w.asid;
      m_pte[upd_w.vpn[1:0]]  <= upd_w.pte;
      m_4m[upd_w.vpn[1:0]]   <= upd_w.is_4M;
    end
  end

  always_comb begin
    tlb_lu_hit_i     = 1'b0;
    tlb_lu_content_i = '0;
    tlb_lu_is_4M_i   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_v[i] && (m_asid[i][0] == tlb_lu_asid_o[0]) &&
          (m_4m[i] ? (m_vpn[i][19:10] == tlb_lu_vaddr_o[31:22])
                   : (m_vpn[i] == tlb_lu_vaddr_o[31:12]))) begin
        tlb_lu_hit_i     = 1'b1;
        tlb_lu_content_i = m_pte[i];
        tlb_lu_is_4M_i   = m_4m[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".i_gnt"},     64'(i_gnt_o), 64'd0);
    chk({tag, ".d_gnt"},     64'(d_gnt_o), 64'd0);
    chk({tag, ".upd_gnt"},   64'(upd_gnt_o), 64'd0);
    chk({tag, ".flush_gnt"}, 64'(flush_gnt_o), 64'd0);
    chk({tag, ".i_rvalid"},  64'(i_rvalid_o), 64'd0);
    chk({tag, ".d_rvalid"},  64'(d_rvalid_o), 64'd0);
    chk({tag, ".rhit"},      64'(rhit_o), 64'd0);
    chk({tag, ".rcontent"},  64'(rcontent_o), 64'd0);
    chk({tag, ".ris_4M"},    64'(ris_4M_o), 64'd0);
    chk({tag, ".busy"},      64'(busy_o), 64'd0);
    chk({tag, ".tlb_flush"}, 64'(tlb_flush_o), 64'd0);
    chk({tag, ".tlb_update"},64'(tlb_update_o), 64'd0);
    chk({tag, ".tlb_lu_acc"},64'(tlb_lu_access_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [61:0] d1;
    rst_ni = 1'b0;
    i_req_i = 1'b1; d_req_i = 1'b1; upd_req_i = 1'b1; flush_req_i = 1'b1;
    i_vaddr_i = 32'h12345000; d_vaddr_i = '0; i_asid_i = 1'b1; d_asid_i = 1'b0;
    upd_data_i = '0; flush_asid_i = 1'b0; flush_vaddr_i = '0;

    // reset state, even with every request raised
    nxt(); nxt(); #1;
    chk_all_zero("reset");
    i_req_i = 1'b0; d_req_i = 1'b0; upd_req_i = 1'b0; flush_req_i = 1'b0;
    nxt(); rst_ni = 1'b1; #1;
    chk("idle.i_gnt", 64'(i_gnt_o), 64'd0);

    // lookup without competition, right after an update
    nxt();
    d1 = {1'b0, 20'h12345, 9'd1, 32'hDEADBEEF};
    upd_req_i = 1'b1; upd_data_i = d1; #1;
    chk("t1.upd_gnt", 64'(upd_gnt_o), 64'd1);
    chk("t1.tlb_update", 64'(tlb_update_o), 64'({1'b1, d1}));
    chk("t1.i_gnt_idle", 64'(i_gnt_o), 64'd0);
    nxt(); upd_req_i = 1'b0; i_req_i = 1'b1; i_vaddr_i = 32'h12345000; i_asid_i = 1'b1; #1;
    chk("t1.i_gnt", 64'(i_gnt_o), 64'd1);
    chk("t1.lu_access", 64'(tlb_lu_access_o), 64'd1);
    chk("t1.lu_vaddr", 64'(tlb_lu_vaddr_o), 64'h12345000);
    chk("t1.upd_gnt_off", 64'(upd_gnt_o), 64'd0);
    nxt(); i_req_i = 1'b0; #1;
    chk("t1.i_rvalid", 64'(i_rvalid_o), 64'd1);
    chk("t1.d_rvalid", 64'(d_rvalid_o), 64'd0);
    chk("t1.rhit", 64'(rhit_o), 64'd1);
    chk("t1.rcontent", 64'(rcontent_o), 64'hDEADBEEF);
    chk("t1.ris_4M", 64'(ris_4M_o), 64'd0);
    nxt(); #1;
    chk("t1.rvalid_pulse", 64'(i_rvalid_o), 64'd0);
    chk("t1.rcontent_hold", 64'(rcontent_o), 64'hDEADBEEF);

    // concurrent I and D: alternate I, D, I, D with 1-cycle responses
    nxt();
    i_req_i = 1'b1; d_req_i = 1'b1; d_vaddr_i = 32'h0ABCD000; d_asid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t2.i_gnt%0d", k), 64'(i_gnt_o), 64'((k % 2) == 0));
      chk($sformatf("t2.d_gnt%0d", k), 64'(d_gnt_o), 64'((k % 2) == 1));
      if (k > 0) begin
        chk($sformatf("t2.i_rvalid%0d", k), 64'(i_rvalid_o), 64'((k % 2) == 1));
        chk($sformatf("t2.d_rvalid%0d", k), 64'(d_rvalid_o), 64'((k % 2) == 0));
        chk($sformatf("t2.rhit%0d", k), 64'(rhit_o), 64'((k % 2) == 1));
      end
      nxt();
    end
    i_req_i = 1'b0; d_req_i = 1'b0; #1;
    chk("t2.d_rvalid_last", 64'(d_rvalid_o), 64'd1);
    chk("t2.i_rvalid_last", 64'(i_rvalid_o), 64'd0);
    chk("t2.rhit_last", 64'(rhit_o), 64'd0);

    // flush beats update beats lookup; HOLD cycle; flushed entry misses
    nxt();
    flush_req_i = 1'b1; flush_asid_i = 1'b0; flush_vaddr_i = '0;
    upd_req_i = 1'b1; upd_data_i = {1'b0, 20'h00077, 9'd0, 32'h00007777};
    i_req_i = 1'b1; i_vaddr_i = 32'h12345000; i_asid_i = 1'b1; #1;
    chk("t3.flush_gnt", 64'(flush_gnt_o), 64'd1);
    chk("t3.tlb_flush", 64'(tlb_flush_o), 64'd1);
    chk("t3.upd_gnt0", 64'(upd_gnt_o), 64'd0);
    chk("t3.i_gnt0", 64'(i_gnt_o), 64'd0);
    nxt(); flush_req_i = 1'b0; #1;
    chk("t3.busy", 64'(busy_o), 64'd1);
    chk("t3.upd_gnt1", 64'(upd_gnt_o), 64'd0);
    chk("t3.i_gnt1", 64'(i_gnt_o), 64'd0);
    chk("t3.tlb_update1", 64'(tlb_update_o), 64'd0);
    nxt(); #1;
    chk("t3.upd_gnt2", 64'(upd_gnt_o), 64'd1);
    chk("t3.i_gnt2", 64'(i_gnt_o), 64'd0);
    chk("t3.busy2", 64'(busy_o), 64'd0);
    nxt(); upd_req_i = 1'b0; #1;
    chk("t3.i_gnt3", 64'(i_gnt_o), 64'd1);
    nxt(); i_req_i = 1'b0; #1;
    chk("t3.i_rvalid", 64'(i_rvalid_o), 64'd1);
    chk("t3.rhit_flushed", 64'(rhit_o), 64'd0);

    // update burst bound: 4 updates, one D lookup, updates resume
    nxt();
    upd_req_i = 1'b1; upd_data_i = {1'b0, 20'h00100, 9'd0, 32'hA5A50000};
    d_req_i = 1'b1; d_vaddr_i = 32'h00077000; d_asid_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t4.upd_gnt%0d", k), 64'(upd_gnt_o), 64'(!(k == 4 || k == 9)));
      chk($sformatf("t4.d_gnt%0d", k), 64'(d_gnt_o), 64'(k == 4 || k == 9));
      if (k == 5) begin
        chk("t4.d_rvalid", 64'(d_rvalid_o), 64'd1);
        chk("t4.rhit", 64'(rhit_o), 64'd1);
        chk("t4.rcontent", 64'(rcontent_o), 64'h00007777);
      end
      nxt();
    end
    upd_req_i = 1'b0; d_req_i = 1'b0; #1;
    chk("t4.d_rvalid_end", 64'(d_rvalid_o), 64'd1);

    // reset in the cycle after a grant drops the response
    nxt();
    i_req_i = 1'b1; i_vaddr_i = 32'h00077000; i_asid_i = 1'b0; #1;
    chk("t5.i_gnt", 64'(i_gnt_o), 64'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0; d_req_i = 1'b1; upd_req_i = 1'b1; flush_req_i = 1'b1;
    nxt(); #1;
    chk_all_zero("t5.rst");
    nxt();
    d_req_i = 1'b0; upd_req_i = 1'b0; flush_req_i = 1'b0; rst_ni = 1'b1; #1;
    chk("t5.i_gnt_after", 64'(i_gnt_o), 64'd1);
    nxt(); i_req_i = 1'b0; #1;
    chk("t5.i_rvalid_after", 64'(i_rvalid_o), 64'd1);
    chk("t5.rhit_after", 64'(rhit_o), 64'd1);
    chk("t5.rcontent_after", 64'(rcontent_o), 64'h00007777);

    // lookup result still returns in the cycle a flush is granted
    nxt();
    i_req_i = 1'b1; #1;
    chk("t6.i_gnt", 64'(i_gnt_o), 64'd1);
    nxt(); i_req_i = 1'b0; flush_req_i = 1'b1; #1;
    chk("t6.flush_gnt", 64'(flush_gnt_o), 64'd1);
    chk("t6.i_rvalid", 64'(i_rvalid_o), 64'd1);
    chk("t6.rhit", 64'(rhit_o), 64'd1);
    nxt(); flush_req_i = 1'b0; #1;
    chk("t6.busy", 64'(busy_o), 64'd1);
    chk("t6.i_rvalid_gone", 64'(i_rvalid_o), 64'd0);
    nxt(); #1;
    chk("t6.busy_clear", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
